// File: rtl/mult_div_seq.sv
// Sequential signed multiply/divide unit feeding the HI/LO registers.
// MULT uses radix-2 Booth, DIV uses restoring division on magnitudes with sign fix-up.
module mult_div_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op_ctrl,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MULT   = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]         state;
    logic [5:0]         count;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH+1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;

    logic [WIDTH:0]     booth_upper;
    logic [2*WIDTH+1:0] booth_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last_iter;

    assign busy      = (state == S_MULT) || (state == S_DIV);
    assign a_mag     = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_mag     = b_in[WIDTH-1] ? -b_in : b_in;
    assign last_iter = (count == 6'(ITER - 1));

    // The upper field is one bit wider than the operand so that subtracting
    // -2^31 cannot overflow before the arithmetic shift.
    always_comb begin
        booth_upper = acc[2*WIDTH+1:WIDTH+1];
        case (acc[1:0])
            2'b01:   booth_upper = acc[2*WIDTH+1:WIDTH+1] + {operand[WIDTH-1], operand};
            2'b10:   booth_upper = acc[2*WIDTH+1:WIDTH+1] - {operand[WIDTH-1], operand};
            default: booth_upper = acc[2*WIDTH+1:WIDTH+1];
        endcase
        booth_next = {booth_upper[WIDTH], booth_upper, acc[WIDTH:1]};
    end

    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, operand};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            operand  <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_ctrl == 2'b01) begin
                        operand <= a_in;
                        acc     <= {{(WIDTH+1){1'b0}}, b_in, 1'b0};
                        count   <= '0;
                        is_div  <= 1'b0;
                        state   <= S_MULT;
                    end else if (op_ctrl == 2'b10) begin
                        if (b_in == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            operand <= b_mag;
                            quo     <= a_mag;
                            rem     <= '0;
                            sign_a  <= a_in[WIDTH-1];
                            sign_b  <= b_in[WIDTH-1];
                            count   <= '0;
                            is_div  <= 1'b1;
                            state   <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc   <= booth_next;
                    count <= count + 6'd1;
                    if (last_iter) state <= S_FINISH;
                end
                S_DIV: begin
                    // The remainder stays below the divisor, so the shifted value never exceeds WIDTH bits.
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 6'd1;
                    if (last_iter) state <= S_FINISH;
                end
                default: begin
                    if (is_div) begin
                        lo_out <= (sign_a ^ sign_b) ? -quo : quo;
                        hi_out <= sign_a ? -rem : rem;
                    end else begin
                        hi_out <= acc[2*WIDTH:WIDTH+1];
                        lo_out <= acc[WIDTH:1];
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
